// File: rtl/reflet_float_acc_pkg.sv
// Shared float format split and helpers for the reflet float accumulator slice.
package reflet_float_acc_pkg;

    // Exponent width for the supported IEEE-754 style widths; the rest is mantissa plus sign.
    function automatic int unsigned exponent_size(input int unsigned float_size);
        case (float_size)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned mantissa_size(input int unsigned float_size);
        return float_size - exponent_size(float_size) - 1;
    endfunction

endpackage

// File: rtl/reflet_float_add.sv
// Combinational float adder/subtractor; zeros/denormals flush to zero, result truncated.
module reflet_float_add
    import reflet_float_acc_pkg::*;
#(
    parameter int unsigned float_size = 32
) (
    input  logic                  enable_add,
    input  logic                  enable_sub,
    input  logic [float_size-1:0] in1,
    input  logic [float_size-1:0] in2,
    output logic [float_size-1:0] out
);
    localparam int unsigned ES  = exponent_size(float_size);
    localparam int unsigned MS  = mantissa_size(float_size);
    localparam int unsigned MW  = MS + 4;
    localparam int unsigned LZW = $clog2(MW + 2);

    logic          sign_a, sign_b;
    logic [ES-1:0] exp_a, exp_b;
    logic [MS-1:0] man_a, man_b;

    assign sign_a = in1[float_size-1];
    assign exp_a  = in1[float_size-2 -: ES];
    assign man_a  = in1[MS-1:0];
    assign sign_b = in2[float_size-1] ^ enable_sub;
    assign exp_b  = in2[float_size-2 -: ES];
    assign man_b  = in2[MS-1:0];

    logic          a_big, big_sign, small_sign;
    logic [ES-1:0] big_exp, small_exp, diff;
    logic [MW-1:0] big_m, small_m, small_sh;
    logic [MW:0]   sum, norm;
    logic [LZW-1:0] lz;
    logic [ES+1:0] exp_res;
    logic          underflow, overflow;

    // Align the smaller magnitude onto the larger, add or subtract, then renormalise.
    always_comb begin
        a_big      = {exp_a, man_a} >= {exp_b, man_b};
        big_sign   = a_big ? sign_a : sign_b;
        small_sign = a_big ? sign_b : sign_a;
        big_exp    = a_big ? exp_a : exp_b;
        small_exp  = a_big ? exp_b : exp_a;
        big_m      = a_big ? {1'b1, man_a, 3'b000} : {1'b1, man_b, 3'b000};
        small_m    = a_big ? {1'b1, man_b, 3'b000} : {1'b1, man_a, 3'b000};
        diff       = big_exp - small_exp;
        small_sh   = small_m >> diff;
        if (big_sign == small_sign) begin
            sum = {1'b0, big_m} + {1'b0, small_sh};
        end else begin
            sum = {1'b0, big_m} - {1'b0, small_sh};
        end
        lz = LZW'(MW + 1);
        for (int i = 0; i <= int'(MW); i++) begin
            if (sum[i]) lz = LZW'(int'(MW) - i);
        end
        norm      = sum << lz;
        exp_res   = (ES+2)'(big_exp) + (ES+2)'(1) - (ES+2)'(lz);
        underflow = exp_res[ES+1] || (exp_res == '0);
        overflow  = !exp_res[ES+1] && (exp_res[ES] || (&exp_res[ES-1:0]));

        if (!enable_add || exp_b == '0) begin
            out = in1;
        end else if (exp_a == '0) begin
            out = {sign_b, exp_b, man_b};
        end else if (sum == '0) begin
            out = '0;
        end else if (underflow) begin
            out = {big_sign, {(float_size-1){1'b0}}};
        end else if (overflow) begin
            out = {big_sign, {ES{1'b1}}, {MS{1'b0}}};
        end else begin
            out = {big_sign, exp_res[ES-1:0], norm[MW-1 -: MS]};
        end
    end

endmodule

// File: rtl/reflet_float_acc.sv
// Packet float accumulator: sums (or subtracts) a stream of floats, presents sum and element count.
module reflet_float_acc
    import reflet_float_acc_pkg::*;
#(
    parameter int unsigned float_size = 32,
    parameter int unsigned count_size = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [float_size-1:0] in_data,
    input  logic                  in_sub,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [float_size-1:0] out_sum,
    output logic [count_size-1:0] out_count,
    output logic                  out_valid,
    input  logic                  out_ready
);
    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_e;

    state_e                state_q, state_d;
    logic                  first_q, first_d;
    logic [float_size-1:0] acc_q, acc_d;
    logic [count_size-1:0] count_q, count_d;
    logic [float_size-1:0] add_out;
    logic                  accept;

    reflet_float_add #(.float_size(float_size)) u_add (
        .enable_add (1'b1),
        .enable_sub (in_sub),
        .in1        (acc_q),
        .in2        (in_data),
        .out        (add_out)
    );

    assign accept = in_valid && (state_q == ACCUM);

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        acc_d   = acc_q;
        count_d = count_q;
        if (flush) begin
            state_d = ACCUM;
            first_d = 1'b1;
            acc_d   = '0;
            count_d = '0;
        end else if (state_q == DONE) begin
            if (out_ready) begin
                state_d = ACCUM;
                first_d = 1'b1;
            end
        end else if (accept) begin
            first_d = 1'b0;
            // First element bypasses the adder so a stale accumulator never leaks in.
            if (first_q) begin
                acc_d   = {in_data[float_size-1] ^ in_sub, in_data[float_size-2:0]};
                count_d = count_size'(1);
            end else begin
                acc_d   = add_out;
                count_d = (&count_q) ? count_q : count_q + count_size'(1);
            end
            if (in_last) state_d = DONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACCUM;
            first_q <= 1'b1;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_reflet_float_acc.sv
// Directed bench for reflet_float_acc: default instance plus a count_size=2 instance for saturation.
module tb_reflet_float_acc;
    logic        clk = 1'b0;
    logic        reset, flush, in_sub, in_last, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [31:0] out_sum, out_sum2;
    logic [7:0]  out_count;
    logic [1:0]  out_count2;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reflet_float_acc dut (
        .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_sub(in_sub),
        .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready), .out_sum(out_sum),
        .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
    );

    reflet_float_acc #(.float_size(32), .count_size(2)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_sub(in_sub),
        .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready2), .out_sum(out_sum2),
        .out_count(out_count2), .out_valid(out_valid2), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic l);
        int n = 0;
        in_data  = d;
        in_sub   = s;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_sub   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] sum, input logic [7:0] cnt);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, out_sum, sum);
        check({tag, "_count"}, 32'(out_count), 32'(cnt));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_again"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_sub = 1'b0; in_last = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum", out_sum, 32'h0);
        check("rst_count", 32'(out_count), 32'd0);
        reset = 1'b1;
        step();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_ready_sat", 32'(in_ready2), 32'd1);

        // Addition, latency 1 after last.
        send(32'h3F800000, 1'b0, 1'b0);
        check("add_no_early_valid", 32'(out_valid), 32'd0);
        send(32'h40000000, 1'b0, 1'b1);
        expect_result("add", 32'h40400000, 8'd2);

        // Subtraction and exact cancellation.
        send(32'h40400000, 1'b0, 1'b0);
        send(32'h3F800000, 1'b1, 1'b1);
        expect_result("sub", 32'h40000000, 8'd2);
        send(32'h40000000, 1'b0, 1'b0);
        send(32'h40000000, 1'b1, 1'b1);
        expect_result("cancel", 32'h00000000, 8'd2);

        // Single subtracted element.
        send(32'h40000000, 1'b1, 1'b1);
        expect_result("single", 32'hC0000000, 8'd1);

        // Backpressure: result held, offered element ignored.
        send(32'h3F800000, 1'b0, 1'b1);
        in_data = 32'h40000000; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum", out_sum, 32'h3F800000);
            check("bp_count", 32'(out_count), 32'd1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        expect_result("bp", 32'h3F800000, 8'd1);
        send(32'h40000000, 1'b0, 1'b1);
        expect_result("bp_fresh", 32'h40000000, 8'd1);

        // Saturation of a 2-bit counter over 5 elements.
        for (int i = 0; i < 5; i++) send(32'h3F800000, 1'b0, (i == 4));
        check("sat_valid", 32'(out_valid2), 32'd1);
        check("sat_count", 32'(out_count2), 32'd3);
        check("sat_sum", out_sum2, 32'h40A00000);
        expect_result("sat_wide", 32'h40A00000, 8'd5);

        // Flush mid-packet.
        send(32'h40000000, 1'b0, 1'b0);
        send(32'h40400000, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_sum", out_sum, 32'h0);
        check("flush_count", 32'(out_count), 32'd0);
        send(32'h3F000000, 1'b0, 1'b0);
        send(32'h3F800000, 1'b0, 1'b1);
        expect_result("after_flush", 32'h3FC00000, 8'd2);

        // Flush while a result is pending drops it.
        send(32'h40000000, 1'b0, 1'b1);
        check("flush_done_pre", 32'(out_valid), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_done_drop", 32'(out_valid), 32'd0);
        check("flush_done_ready", 32'(in_ready), 32'd1);

        // Reset mid-packet.
        send(32'h40000000, 1'b0, 1'b0);
        send(32'h40400000, 1'b0, 1'b0);
        reset = 1'b0;
        #2;
        check("rst_mid_count", 32'(out_count), 32'd0);
        check("rst_mid_sum", out_sum, 32'h0);
        step();
        reset = 1'b1;
        step();
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        send(32'h3F000000, 1'b0, 1'b0);
        send(32'h3F800000, 1'b0, 1'b1);
        expect_result("after_reset", 32'h3FC00000, 8'd2);

        // Reset while DONE discards the result.
        send(32'h40000000, 1'b0, 1'b1);
        reset = 1'b0;
        #2;
        check("rst_done_valid", 32'(out_valid), 32'd0);
        step();
        reset = 1'b1;
        step();
        check("rst_done_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
